// File: rtl/sram_model_pkg.sv
// rtl/sram_model_pkg.sv - shared constants, parameter checks and message formatting for SRAM models
package sram_model_pkg;

    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 4;

    // Number of write-mask lanes; a zero lane size is caught by lanes_ok().
    function automatic int num_wmasks(input int data_width, input int write_size);
        return (write_size > 0) ? (data_width / write_size) : 1;
    endfunction

    // Depth must be non-empty and addressable with addr_width bits.
    function automatic bit depth_ok(input int num_words, input int addr_width);
        return (num_words >= 1) && (addr_width >= 1) && (addr_width < 63) &&
               (longint'(num_words) <= (longint'(1) << addr_width));
    endfunction

    // Word must split into whole lanes.
    function automatic bit lanes_ok(input int data_width, input int write_size);
        return (write_size > 0) && (data_width > 0) && ((data_width % write_size) == 0);
    endfunction

    function automatic bit latency_ok(input int read_latency);
        return (read_latency >= RD_LAT_MIN) && (read_latency <= RD_LAT_MAX);
    endfunction

    function automatic string fmt_write(input time t, input string addr_h, input string data_h,
                                        input string mask_h);
        return $sformatf("%0t sram port0 write addr=0x%s data=0x%s mask=0x%s", t, addr_h, data_h, mask_h);
    endfunction

    function automatic string fmt_read(input time t, input int port, input string addr_h,
                                       input string data_h);
        return $sformatf("%0t sram port%0d read addr=0x%s data=0x%s", t, port, addr_h, data_h);
    endfunction

    function automatic string fmt_warn(input time t, input int port, input string what,
                                       input string addr_h);
        return $sformatf("%0t sram WARNING port%0d %s addr=0x%s out of range", t, port, what, addr_h);
    endfunction

endpackage

// File: rtl/sram_rd_pipe.sv
// rtl/sram_rd_pipe.sv - fixed-depth data+valid delay line for one SRAM read port
module sram_rd_pipe #(
    parameter int DATA_WIDTH = 32,
    parameter int LATENCY    = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  s_tvalid,
    input  logic [DATA_WIDTH-1:0] s_tdata,
    output logic                  m_tvalid,
    output logic [DATA_WIDTH-1:0] m_tdata
);

    logic [LATENCY-1:0]    vld;
    logic [DATA_WIDTH-1:0] dat [LATENCY];

    // Shift valids every cycle; data stages only load behind a valid so the
    // last stage holds the most recent read result while idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                dat[i] <= '0;
            end
        end else begin
            vld[0] <= s_tvalid;
            if (s_tvalid) begin
                dat[0] <= s_tdata;
            end
            for (int i = 1; i < LATENCY; i++) begin
                vld[i] <= vld[i-1];
                if (vld[i-1]) begin
                    dat[i] <= dat[i-1];
                end
            end
        end
    end

    assign m_tvalid = vld[LATENCY-1];
    assign m_tdata  = dat[LATENCY-1];

endmodule

// File: rtl/sram_1rw1r_wmask.sv
// rtl/sram_1rw1r_wmask.sv - behavioural 1RW1R SRAM with lane write masks, read pipeline and collision count
module sram_1rw1r_wmask
    import sram_model_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 8,
    parameter int NUM_WORDS    = 256,
    parameter int WRITE_SIZE   = 8,
    parameter int READ_LATENCY = 1,
    parameter int CNT_WIDTH    = 16,
    parameter int VERBOSE      = 1
) (
    input  logic                                             clk0,
    input  logic                                             rstb0,
    input  logic                                             csb0,
    input  logic                                             web0,
    input  logic [num_wmasks(DATA_WIDTH, WRITE_SIZE)-1:0]    wmask0,
    input  logic [ADDR_WIDTH-1:0]                            addr0,
    input  logic [DATA_WIDTH-1:0]                            din0,
    output logic [DATA_WIDTH-1:0]                            dout0,
    output logic                                             dout0_valid,
    input  logic                                             csb1,
    input  logic [ADDR_WIDTH-1:0]                            addr1,
    output logic [DATA_WIDTH-1:0]                            dout1,
    output logic                                             dout1_valid,
    output logic                                             collision,
    output logic [CNT_WIDTH-1:0]                             collision_count
);

    localparam int NUM_WMASKS = num_wmasks(DATA_WIDTH, WRITE_SIZE);
    localparam logic [ADDR_WIDTH:0] DEPTH = (ADDR_WIDTH + 1)'(NUM_WORDS);

    if (!depth_ok(NUM_WORDS, ADDR_WIDTH)) begin : g_bad_depth
        $fatal(1, "sram_1rw1r_wmask: NUM_WORDS must be in 1..2**ADDR_WIDTH");
    end
    if (!lanes_ok(DATA_WIDTH, WRITE_SIZE)) begin : g_bad_lanes
        $fatal(1, "sram_1rw1r_wmask: DATA_WIDTH must be a multiple of WRITE_SIZE");
    end
    if (!latency_ok(READ_LATENCY)) begin : g_bad_latency
        $fatal(1, "sram_1rw1r_wmask: READ_LATENCY must be in 1..4");
    end

    logic [DATA_WIDTH-1:0] mem [NUM_WORDS];

    logic                  wr0;
    logic                  rd0;
    logic                  rd1;
    logic                  in0;
    logic                  in1;
    logic                  coll_hit;
    logic [DATA_WIDTH-1:0] rdata0;
    logic [DATA_WIDTH-1:0] rdata1;
    logic [DATA_WIDTH-1:0] wr_merged;

    logic                  cap0_v;
    logic                  cap1_v;
    logic [DATA_WIDTH-1:0] cap0_d;
    logic [DATA_WIDTH-1:0] cap1_d;

    // Nothing is accepted while reset is held low.
    assign wr0 = rstb0 & ~csb0 & ~web0;
    assign rd0 = rstb0 & ~csb0 & web0;
    assign rd1 = rstb0 & ~csb1;

    assign in0 = ({1'b0, addr0} < DEPTH);
    assign in1 = ({1'b0, addr1} < DEPTH);

    // Out-of-range reads return zero rather than touching the array.
    assign rdata0 = in0 ? mem[addr0] : '0;
    assign rdata1 = in1 ? mem[addr1] : '0;

    // A masked write with no lanes set changes nothing, so it cannot conflict.
    assign coll_hit = wr0 & rd1 & in0 & (addr0 == addr1) & (|wmask0);

    // Merge the enabled lanes of din0 over the currently stored word.
    always_comb begin
        wr_merged = rdata0;
        for (int i = 0; i < NUM_WMASKS; i++) begin
            if (wmask0[i]) begin
                wr_merged[i*WRITE_SIZE +: WRITE_SIZE] = din0[i*WRITE_SIZE +: WRITE_SIZE];
            end
        end
    end

    // Array update; contents deliberately survive reset.
    always_ff @(posedge clk0) begin
        if (wr0 && in0 && (|wmask0)) begin
            mem[addr0] <= wr_merged;
        end
    end

    // Capture the array word at the request edge so a same-edge write is not seen.
    always_ff @(posedge clk0 or negedge rstb0) begin
        if (!rstb0) begin
            cap0_v <= 1'b0;
            cap1_v <= 1'b0;
            cap0_d <= '0;
            cap1_d <= '0;
        end else begin
            cap0_v <= rd0;
            cap1_v <= rd1;
            if (rd0) begin
                cap0_d <= rdata0;
            end
            if (rd1) begin
                cap1_d <= rdata1;
            end
        end
    end

    // Collision pulse and saturating event counter.
    always_ff @(posedge clk0 or negedge rstb0) begin
        if (!rstb0) begin
            collision       <= 1'b0;
            collision_count <= '0;
        end else begin
            collision <= coll_hit;
            if (coll_hit && (collision_count != {CNT_WIDTH{1'b1}})) begin
                collision_count <= collision_count + CNT_WIDTH'(1);
            end
        end
    end

    sram_rd_pipe #(
        .DATA_WIDTH (DATA_WIDTH),
        .LATENCY    (READ_LATENCY)
    ) u_rd_pipe0 (
        .clk      (clk0),
        .rst_n    (rstb0),
        .s_tvalid (cap0_v),
        .s_tdata  (cap0_d),
        .m_tvalid (dout0_valid),
        .m_tdata  (dout0)
    );

    sram_rd_pipe #(
        .DATA_WIDTH (DATA_WIDTH),
        .LATENCY    (READ_LATENCY)
    ) u_rd_pipe1 (
        .clk      (clk0),
        .rst_n    (rstb0),
        .s_tvalid (cap1_v),
        .s_tdata  (cap1_d),
        .m_tvalid (dout1_valid),
        .m_tdata  (dout1)
    );

    // Access trace and out-of-range warnings.
    always_ff @(posedge clk0) begin
        if (wr0 && !in0) begin
            $display("%s", fmt_warn($time, 0, "write dropped", $sformatf("%h", addr0)));
        end
        if (rd0 && !in0) begin
            $display("%s", fmt_warn($time, 0, "read returns zero", $sformatf("%h", addr0)));
        end
        if (rd1 && !in1) begin
            $display("%s", fmt_warn($time, 1, "read returns zero", $sformatf("%h", addr1)));
        end
        if (VERBOSE != 0) begin
            if (wr0) begin
                $display("%s", fmt_write($time, $sformatf("%h", addr0), $sformatf("%h", din0),
                                         $sformatf("%h", wmask0)));
            end
            if (rd0) begin
                $display("%s", fmt_read($time, 0, $sformatf("%h", addr0), $sformatf("%h", rdata0)));
            end
            if (rd1) begin
                $display("%s", fmt_read($time, 1, $sformatf("%h", addr1), $sformatf("%h", rdata1)));
            end
        end
    end

endmodule

// File: doc/sram_1rw1r_wmask.md
Name: sram_1rw1r_wmask

Overview:
- Parametrised behavioural SRAM model with one read/write port (port 0) and one read-only port (port 1), both on a single clock.
- Next generation of the single-port RW macro model: adds
  - byte-granular write masks
  - a configurable read pipeline with valid flags
  - non-power-of-two depth
  - same-cycle collision detection and counting
- Used as the simulation/verification stand-in for generated 1RW1R macros in SoC-level benches.

Parameters:
- DATA_WIDTH, 32, bits per word.
- ADDR_WIDTH, 8, address bits.
- NUM_WORDS, 256, implemented depth; must be <= 2**ADDR_WIDTH.
- WRITE_SIZE, 8, bits per write-mask lane. DATA_WIDTH must be a multiple of WRITE_SIZE. NUM_WMASKS = DATA_WIDTH/WRITE_SIZE.
- READ_LATENCY, 1, cycles from capture edge to read data; legal values 1..4.
- CNT_WIDTH, 16, collision counter width.
- VERBOSE, 1, 0 suppresses per-access $display (warnings always printed).

Ports:
- clk0  in  1  clock; all activity on the rising edge.
- rstb0  in  1  asynchronous, active-low reset.
- csb0  in  1  port-0 active-low chip select.
- web0  in  1  port-0 active-low write enable.
- wmask0  in  NUM_WMASKS  port-0 lane write enables, active-high.
- addr0  in  ADDR_WIDTH  port-0 address.
- din0  in  DATA_WIDTH  port-0 write data.
- dout0  out  DATA_WIDTH  port-0 read data.
- dout0_valid  out  1  port-0 read data valid.
- csb1  in  1  port-1 active-low chip select.
- addr1  in  ADDR_WIDTH  port-1 address.
- dout1  out  DATA_WIDTH  port-1 read data.
- dout1_valid  out  1  port-1 read data valid.
- collision  out  1  one-cycle pulse on a write/read same-address conflict.
- collision_count  out  CNT_WIDTH  saturating count of collisions.

Behaviour:
- Reset (rstb0 low, asynchronous):
  - dout0, dout1, collision and collision_count go to 0.
  - Both valids go to 0.
  - Read pipelines are flushed; in-flight reads are dropped and never produce a valid.
  - Array contents are NOT cleared.
  - While rstb0 is low, no access is accepted.
  - Deassertion is sampled synchronously: the first accepted request is at the first rising edge with rstb0 high.
- Capture: csb0, web0, wmask0, addr0, din0, csb1 and addr1 are sampled at rising edge N.
- Write (csb0=0, web0=0):
  - At edge N, lane i of mem[addr0] gets din0 lane i for every wmask0[i]=1; other lanes are unchanged.
  - wmask0 all-zero is a legal no-op; it is not a collision.
  - The write is visible to reads captured at edge N+1 or later.
- Read port 0 (csb0=0, web0=1): array read at edge N; dout0 and dout0_valid=1 are presented after edge N+READ_LATENCY.
- Read port 1 (csb1=0): same timing, on dout1/dout1_valid.
- Valid timing:
  - Each valid is high for exactly one cycle per accepted read.
  - Back-to-back reads give back-to-back valids; throughput is 1 read/cycle/port.
- Idle: when no read completes, dout holds its last value and valid=0.
- Out of range (addr >= NUM_WORDS):
  - Write is dropped with a warning.
  - Read returns all-zero with valid=1 and a warning.
- Same-cycle port-0 write and port-1 read, same in-range address, at least one wmask0 bit set:
  - Port 1 returns the pre-write (old) word.
  - Write completes normally.
  - collision=1 for the cycle after edge N.
  - collision_count increments, saturating at all-ones.
- Port-0 read and port-1 read to the same address: legal, both get the same data, no collision.
- VERBOSE=1: one $display per accepted read/write, showing time, port, address and data/mask.
- Parameter checks: illegal combinations (NUM_WORDS > 2**ADDR_WIDTH, DATA_WIDTH % WRITE_SIZE != 0, READ_LATENCY outside 1..4) issue $fatal at elaboration.

Decomposition:
- Package sram_model_pkg:
  - legal READ_LATENCY bounds;
  - the NUM_WMASKS derivation function;
  - shared width-check functions;
  - display-format strings for VERBOSE messages.
- One natural sub-module, sram_rd_pipe:
  - READ_LATENCY-deep data+valid shift pipeline with async active-low reset;
  - instantiated once per read port.
- Array, write-mask merge and collision logic live in the top module.

Test Plan:
- Reset/idle: hold rstb0=0 for 3 cycles, then release with csb0=csb1=1 for 5 cycles -> dout0=dout1=0, both valids 0, collision_count=0 throughout.
- Masked write: DATA_WIDTH=32, WRITE_SIZE=8.
  - Write 0xAABBCCDD to addr 5 with wmask0=4'hF, then write 0x11223344 to addr 5 with wmask0=4'b0101.
  - Port-0 read of addr 5 -> dout0=0xAA22CC44, valid exactly READ_LATENCY cycles after the read edge.
- Latency sweep: for READ_LATENCY=1 and 3, issue reads of addrs 0,1,2 on consecutive cycles on both ports -> three consecutive valid pulses per port, starting READ_LATENCY cycles after the first capture, data in order.
- Collision: mem[9]=0x0.
  - Same edge: port-0 write 0xDEADBEEF to addr 9 (wmask0=4'hF) and port-1 read of addr 9 -> dout1=0x0, collision pulses once, collision_count=1.
  - Next-cycle port-1 read -> 0xDEADBEEF.
  - Repeat with wmask0=0 -> no collision, count stays 1.
- Boundary: NUM_WORDS=200, ADDR_WIDTH=8.
  - Write to addr 200 -> dropped with a warning.
  - Read addr 200 -> dout=0, valid=1.
  - Read addr 199 after writing 0x5 -> 0x5.
- Reset mid-operation: READ_LATENCY=3.
  - Issue a read, assert rstb0 one cycle later -> no valid ever appears for that read, outputs 0 immediately.
  - Array data written before reset reads back intact after reset.
